// File: rtl/branch_resolve_ctrl.sv
// Tracks fetch-stage branch predictions in an in-order queue and resolves them against EX results.
// Mispredictions flush the pipeline, redirect fetch, drain the queue and stall fetch while it recovers.
module branch_resolve_ctrl #(
  parameter int WORD_SIZE      = 16,
  parameter int DEPTH          = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       pred_valid,
  input  logic [WORD_SIZE-1:0]       pred_pc,
  input  logic [WORD_SIZE-1:0]       pred_target,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic [WORD_SIZE-1:0]       res_target,
  output logic                       correct,
  output logic                       flush,
  output logic [WORD_SIZE-1:0]       redirect_pc,
  output logic [15:0]                mispredict_count,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       underflow_err,
  output logic [1:0]                 state_dbg,
  output logic [WORD_SIZE-1:0]       head_pc_dbg
);

  // Handshake: a prediction is recorded on a cycle where pred_valid && pred_ready;
  // pred_valid is a don't-care whenever pred_ready is low. res_valid has no ready:
  // it is consumed in RUN and ignored in FLUSH/RECOVER.

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int RCW = $clog2(RECOVER_CYCLES+1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [RCW-1:0]       rc_cnt, rc_nxt;
  logic [WORD_SIZE-1:0] pc_mem  [DEPTH];
  logic [WORD_SIZE-1:0] tgt_mem [DEPTH];
  logic [PW-1:0]        rd_ptr, wr_ptr;
  logic [CW-1:0]        count;
  logic [15:0]          mis_cnt;

  logic run, res_hit, match, miss, push, pop;

  assign run        = (state == ST_RUN);
  assign pred_ready = run && (count < CW'(DEPTH));
  assign res_hit    = run && res_valid && (count != '0);
  assign match      = res_hit && (res_target == tgt_mem[rd_ptr]);
  assign miss       = res_hit && !match;
  // A push racing a mispredict is wrong-path and must not survive the clear.
  assign push       = pred_valid && pred_ready && !miss;
  assign pop        = match;

  assign outstanding      = count;
  assign mispredict_count = mis_cnt;
  assign state_dbg        = state;
  assign head_pc_dbg      = pc_mem[rd_ptr];

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc_cnt;
    case (state)
      ST_RUN: begin
        if (miss) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        state_nxt = ST_RECOVER;
        rc_nxt    = RCW'(RECOVER_CYCLES - 1);
      end
      ST_RECOVER: begin
        if (rc_cnt == '0) state_nxt = ST_RUN;
        else              rc_nxt    = rc_cnt - RCW'(1);
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_RUN;
      rc_cnt        <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      correct       <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      mis_cnt       <= '0;
      underflow_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      rc_cnt  <= rc_nxt;
      correct <= match;
      flush   <= miss;
      if (run && res_valid && (count == '0)) underflow_err <= 1'b1;
      if (miss) begin
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        count       <= '0;
        redirect_pc <= res_target;
        if (mis_cnt != 16'hFFFF) mis_cnt <= mis_cnt + 16'd1;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= pred_pc;
      tgt_mem[wr_ptr] <= pred_target;
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed and randomized bench for branch_resolve_ctrl, checked against a queue-based
// model that tracks outstanding predictions and the stall window as a simple countdown.
module tb_branch_resolve_ctrl;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          reset_n, pred_valid, res_valid;
  logic [W-1:0]  pred_pc, pred_target, res_target;
  logic          pred_ready, correct, flush, underflow_err;
  logic [W-1:0]  redirect_pc, head_pc_dbg;
  logic [15:0]   mispredict_count;
  logic [2:0]    outstanding;
  logic [1:0]    state_dbg;

  branch_resolve_ctrl #(.WORD_SIZE(W), .DEPTH(D), .RECOVER_CYCLES(RC)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_target(res_target),
    .correct(correct), .flush(flush), .redirect_pc(redirect_pc),
    .mispredict_count(mispredict_count), .outstanding(outstanding),
    .underflow_err(underflow_err), .state_dbg(state_dbg), .head_pc_dbg(head_pc_dbg)
  );

  always #5 clk = ~clk;

  // Reference model: exp_q holds {pc, target} of unresolved predictions, oldest first.
  logic [2*W-1:0] exp_q[$];
  int             blocked;
  logic           e_correct, e_flush, e_und;
  logic [W-1:0]   e_redirect;
  logic [15:0]    e_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    blocked    = 0;
    e_correct  = 1'b0;
    e_flush    = 1'b0;
    e_und      = 1'b0;
    e_redirect = '0;
    e_cnt      = '0;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e_state;
    if (blocked == 0)         e_state = 2'd0;
    else if (blocked == 1+RC) e_state = 2'd1;
    else                      e_state = 2'd2;
    chk({tag, ".correct"},     32'(correct),          32'(e_correct));
    chk({tag, ".flush"},       32'(flush),            32'(e_flush));
    chk({tag, ".redirect"},    32'(redirect_pc),      32'(e_redirect));
    chk({tag, ".mcount"},      32'(mispredict_count), 32'(e_cnt));
    chk({tag, ".outstanding"}, 32'(outstanding),      32'(exp_q.size()));
    chk({tag, ".pred_ready"},  32'(pred_ready),       32'((blocked == 0) && (exp_q.size() < D)));
    chk({tag, ".underflow"},   32'(underflow_err),    32'(e_und));
    chk({tag, ".state"},       32'(state_dbg),        32'(e_state));
    if (exp_q.size() > 0) chk({tag, ".head_pc"}, 32'(head_pc_dbg), 32'(exp_q[0][2*W-1:W]));
  endtask

  // One clock: drive inputs, advance model by the spec rules, compare after the edge.
  task automatic step(input string tag, input logic rn, input logic pv, input logic [W-1:0] pc,
                      input logic [W-1:0] tgt, input logic rv, input logic [W-1:0] rt);
    logic rdy, mis;
    reset_n = rn; pred_valid = pv; pred_pc = pc; pred_target = tgt;
    res_valid = rv; res_target = rt;
    rdy = (blocked == 0) && (exp_q.size() < D);
    mis = 1'b0;
    @(posedge clk);
    #1;
    if (!rn) begin
      model_reset();
    end else if (blocked > 0) begin
      blocked--;
      e_correct = 1'b0;
      e_flush   = 1'b0;
    end else begin
      e_correct = 1'b0;
      e_flush   = 1'b0;
      if (rv) begin
        if (exp_q.size() == 0) e_und = 1'b1;
        else if (exp_q[0][W-1:0] == rt) begin
          void'(exp_q.pop_front());
          e_correct = 1'b1;
        end else begin
          exp_q.delete();
          e_redirect = rt;
          e_flush    = 1'b1;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
          blocked = 1 + RC;
          mis     = 1'b1;
        end
      end
      if (pv && rdy && !mis) exp_q.push_back({pc, tgt});
    end
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    pred_pc = '0; pred_target = '0; res_target = '0;

    // Reset state
    step("reset", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    step("reset", 1'b0, 1'b0, '0, '0, 1'b0, '0);

    // Single correct prediction
    step("t1.push", 1'b1, 1'b1, 16'h0010, 16'h0011, 1'b0, '0);
    step("t1.res",  1'b1, 1'b0, '0, '0, 1'b1, 16'h0011);
    idle("t1.idle", 1);

    // Fill to capacity, drop the overflow push, drain with wrap
    for (int i = 0; i < 4; i++)
      step("t2.fill", 1'b1, 1'b1, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0, '0);
    step("t2.over", 1'b1, 1'b1, 16'h0DEA, 16'h0BAD, 1'b0, '0);
    for (int i = 0; i < 4; i++)
      step("t2.drain", 1'b1, 1'b0, '0, '0, 1'b1, 16'h0200 + 16'(i));
    idle("t2.idle", 1);

    // Mispredict on the oldest of three
    step("t3.push", 1'b1, 1'b1, 16'h0020, 16'h0021, 1'b0, '0);
    step("t3.push", 1'b1, 1'b1, 16'h0030, 16'h0031, 1'b0, '0);
    step("t3.push", 1'b1, 1'b1, 16'h0040, 16'h0041, 1'b0, '0);
    step("t3.miss", 1'b1, 1'b0, '0, '0, 1'b1, 16'h0100);
    idle("t3.recover", 4);

    // Mispredict racing a push; res_valid held through the stall window
    step("t4.push", 1'b1, 1'b1, 16'h0050, 16'h0051, 1'b0, '0);
    step("t4.miss", 1'b1, 1'b1, 16'h0060, 16'h0061, 1'b1, 16'h0777);
    for (int i = 0; i < 3; i++)
      step("t4.hold", 1'b1, 1'b1, 16'h0070, 16'h0051, 1'b1, 16'h0051);
    step("t4.run", 1'b1, 1'b0, '0, '0, 1'b0, '0);

    // Underflow is sticky until reset
    step("t5.under", 1'b1, 1'b0, '0, '0, 1'b1, 16'h1234);
    idle("t5.sticky", 2);
    step("t5.reset", 1'b0, 1'b0, '0, '0, 1'b0, '0);

    // Reset while recovering
    step("t6.push", 1'b1, 1'b1, 16'h0080, 16'h0081, 1'b0, '0);
    step("t6.miss", 1'b1, 1'b0, '0, '0, 1'b1, 16'h0999);
    step("t6.flush", 1'b1, 1'b0, '0, '0, 1'b0, '0);
    step("t6.rst", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    idle("t6.run", 1);

    // Saturation: preload the counter near its ceiling, then mispredict past it
    force dut.mis_cnt = 16'hFFFD;
    #1;
    release dut.mis_cnt;
    e_cnt = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      step("sat.push", 1'b1, 1'b1, 16'h00A0, 16'h00A1, 1'b0, '0);
      step("sat.miss", 1'b1, 1'b0, '0, '0, 1'b1, 16'h0ABC + 16'(i));
      idle("sat.recover", 3);
    end

    // Randomized traffic
    step("rnd.reset", 1'b0, 1'b0, '0, '0, 1'b0, '0);
    for (int i = 0; i < 400; i++) begin
      logic          pv, rv;
      logic [W-1:0]  pc, tgt, rt;
      pv  = 1'($urandom_range(0, 1));
      pc  = W'($urandom);
      tgt = W'($urandom);
      rv  = ($urandom_range(0, 2) == 0);
      if (exp_q.size() > 0 && $urandom_range(0, 7) != 0) rt = exp_q[0][W-1:0];
      else                                               rt = W'($urandom);
      step("rnd", 1'b1, pv, pc, tgt, rv, rt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences the fetch-stage branch predictor against EX-stage branch resolution in the 16-bit pipelined CPU. Fetch pushes every predicted control instruction (PC, predicted next PC) into an in-order queue. EX resolves branches oldest-first. The block compares each resolution with its recorded prediction, pulses `correct` back to the predictor, and on a mismatch issues a pipeline flush with a redirect PC, empties the queue and stalls fetch for a fixed recovery window.

Parameters:
WORD_SIZE, 16, PC and target width
DEPTH, 4, maximum outstanding unresolved predictions (power of 2, >= 2)
RECOVER_CYCLES, 2, fetch stall cycles after a flush pulse (>= 1)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous reset, active-low
pred_valid  input  1  fetch issues a predicted control instruction this cycle
pred_pc  input  WORD_SIZE  PC of that instruction
pred_target  input  WORD_SIZE  predicted next PC
pred_ready  output  1  queue accepts a push this cycle
res_valid  input  1  EX resolved the oldest outstanding control instruction
res_target  input  WORD_SIZE  actual next PC
correct  output  1  registered 1-cycle pulse: head prediction matched
flush  output  1  registered 1-cycle pulse: squash IF/ID/EX younger instructions
redirect_pc  output  WORD_SIZE  fetch target, valid while flush=1
mispredict_count  output  16  saturating count of mispredictions
outstanding  output  $clog2(DEPTH+1)  current queue occupancy
underflow_err  output  1  sticky: res_valid seen with empty queue

Behaviour:
- Reset (reset_n=0 at clk edge): queue empty, pointers 0, state RUN, correct=0, flush=0, redirect_pc=0, mispredict_count=0, outstanding=0, underflow_err=0. Reset mid-flush or mid-recovery aborts the sequence immediately.
- Queue: DEPTH-entry circular FIFO of {pc, target}. Pointers wrap modulo DEPTH. Occupancy counter is separate, so full and empty are unambiguous.
- pred_ready = (state==RUN) && (outstanding<DEPTH). It is combinational from registered state. A pop in the same cycle does not free space.
- Push occurs when pred_valid && pred_ready. When pred_ready=0, pred_valid is ignored and nothing is recorded.
- States:
  - RUN: normal operation.
  - FLUSH: 1 cycle, flush=1.
  - RECOVER: counts RECOVER_CYCLES cycles, then returns to RUN.
- RUN, res_valid=1, queue non-empty: compare res_target with head.target over the full WORD_SIZE bits.
  - Match: pop head. Next cycle correct=1.
  - Mismatch: clear the whole queue (all younger entries are wrong-path). Any same-cycle push is discarded. redirect_pc<=res_target. Next cycle flush=1. State->FLUSH. mispredict_count increments, saturating at 16'hFFFF.
- RUN, res_valid=1, queue empty: no pop, no pulse, underflow_err<=1 (sticky until reset).
- Simultaneous push and matching pop in RUN: both occur; occupancy unchanged.
- FLUSH: flush=1 for exactly this cycle. redirect_pc holds. res_valid and pred_valid are ignored. Next state is RECOVER with counter=RECOVER_CYCLES-1.
- RECOVER: pred_ready=0. res_valid and pred_valid are ignored. When the counter reaches 0, go to RUN on the following cycle; pred_ready returns at the first RUN cycle.
- Latency: resolution to correct/flush is 1 cycle. From mispredict resolve, pred_ready is low for 1+RECOVER_CYCLES cycles after the resolve cycle.
- correct and flush are never both 1.
- redirect_pc retains its last value when flush=0.

Test Plan:
1. Reset, then push (pc=0x0010,tgt=0x0011), then res_valid with res_target=0x0011 -> next cycle correct=1, flush=0, outstanding 1->0, mispredict_count=0.
2. Push 4 entries back-to-back -> outstanding=4, pred_ready=0. A 5th pred_valid is dropped. Resolve all 4 correctly -> 4 correct pulses, outstanding=0, pointers wrapped.
3. Push 3 entries (targets 0x0021, 0x0031, 0x0041). Resolve the first with res_target=0x0100 -> next cycle flush=1, redirect_pc=0x0100, outstanding=0, mispredict_count=1. pred_ready=0 for 3 cycles (RECOVER_CYCLES=2), then 1.
4. Mispredict resolve in the same cycle as a push -> push discarded, outstanding=0 after flush. With res_valid held during FLUSH/RECOVER, no correct pulse and count unchanged.
5. res_valid on an empty queue -> underflow_err=1 and stays 1; no correct/flush. Assert reset_n=0 -> underflow_err=0.
6. reset_n=0 during the RECOVER cycle -> next cycle state RUN, pred_ready=1, flush=0, mispredict_count=0. Preload mispredict_count=0xFFFF via forced mispredicts -> it stays 0xFFFF.
